// File: rtl/warp_issue_stage_pkg.sv
// Shared types for the warp issue stage: instruction field positions,
// the per-warp pending-instruction slot and the per-warp register scoreboard.
package issue_types;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned WID_W     = 6;
    localparam int unsigned REG_IDX_W = 5;

    // Register field positions inside the raw instruction word
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;

    // Default shape of a warp; the top-level parameters default to these
    localparam int unsigned TPW   = 32;
    localparam int unsigned NREGS = 32;

    typedef logic [NREGS-1:0] scoreboard_t;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [TPW-1:0]     mask;
        logic               wr_rd;
    } warp_slot_t;

    // Extract a 5-bit register index starting at bit lsb
    function automatic logic [REG_IDX_W-1:0] reg_field(input logic [INSTR_W-1:0] instr,
                                                       input int unsigned lsb);
        return instr[lsb +: REG_IDX_W];
    endfunction

endpackage

// File: rtl/warp_issue_stage_rr_arbiter.sv
// Round-robin arbiter: returns the first requester at or after ptr_i,
// wrapping from N-1 back to 0. Purely combinational.
module rr_arbiter #(
    parameter  int unsigned N  = 32,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_grant_o
);

    logic [IW:0]   cand_sum;
    logic [IW-1:0] cand;

    // Scan N candidates starting at the pointer, keep the first requester
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so no latch is inferred.
        grant_o     = '0;
        idx_o       = '0;
        any_grant_o = 1'b0;
        cand_sum    = '0;
        cand        = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand_sum = {1'b0, ptr_i} + (IW+1)'(off);
            if (cand_sum >= (IW+1)'(N)) begin
                cand_sum = cand_sum - (IW+1)'(N);
            end
            cand = cand_sum[IW-1:0];
            if (!any_grant_o && req_i[cand]) begin
                any_grant_o = 1'b1;
                idx_o       = cand;
            end
        end
        if (any_grant_o) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/warp_issue_stage.sv
// Warp issue stage: one pending instruction per warp, a per-warp register
// scoreboard blocking RAW/WAW hazards, a round-robin pick among hazard-free
// warps and a registered valid/ready output to the execution unit.
// Optional build macro ISSUE_STALL_CNT_EN adds saturating stall counters
// stall_hazard_cnt and stall_exec_cnt.
module warp_issue_stage
    import issue_types::*;
#(
    parameter int unsigned NUM_WARPS        = 32,
    parameter int unsigned THREADS_PER_WARP = TPW,
    parameter int unsigned NUM_REGS         = NREGS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fetch_valid,
    output logic                        fetch_ready,
    input  logic [WID_W-1:0]            fetch_warp_id,
    input  logic [INSTR_W-1:0]          fetch_instr,
    input  logic [THREADS_PER_WARP-1:0] fetch_mask,
    input  logic                        fetch_wr_rd,
    output logic                        exec_valid,
    input  logic                        exec_ready,
    output logic [INSTR_W-1:0]          exec_instr,
    output logic [THREADS_PER_WARP-1:0] exec_mask,
    output logic [WID_W-1:0]            exec_warp_id,
    input  logic                        wb_valid,
    input  logic [WID_W-1:0]            wb_warp_id,
    input  logic [REG_IDX_W-1:0]        wb_rd
`ifdef ISSUE_STALL_CNT_EN
    ,
    output logic [31:0]                 stall_hazard_cnt,
    output logic [31:0]                 stall_exec_cnt
`endif
);

    localparam int unsigned WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    warp_slot_t  slot_q [NUM_WARPS];
    warp_slot_t  slot_d [NUM_WARPS];
    scoreboard_t sb_q   [NUM_WARPS];
    scoreboard_t sb_d   [NUM_WARPS];

    logic [WW-1:0]               rr_ptr_q, rr_ptr_d;
    logic                        exec_valid_q;
    logic [INSTR_W-1:0]          exec_instr_q;
    logic [THREADS_PER_WARP-1:0] exec_mask_q;
    logic [WID_W-1:0]            exec_warp_id_q;

    logic [NUM_WARPS-1:0] slot_valid;
    logic [NUM_WARPS-1:0] eligible;
    logic [NUM_WARPS-1:0] grant;
    logic [WW-1:0]        pick_idx;
    logic                 any_elig;
    logic                 load;
    logic [WW-1:0]        fetch_idx;
    logic                 fetch_in_range;
    logic                 fetch_accept;
    logic [WW-1:0]        wb_idx;
    logic                 wb_in_range;

    assign fetch_idx      = fetch_warp_id[WW-1:0];
    assign fetch_in_range = {1'b0, fetch_warp_id} < (WID_W+1)'(NUM_WARPS);
    assign wb_idx         = wb_warp_id[WW-1:0];
    assign wb_in_range    = {1'b0, wb_warp_id} < (WID_W+1)'(NUM_WARPS);

    // A slot freed by this cycle's issue is not offered back until next cycle
    assign fetch_ready  = fetch_in_range && !slot_q[fetch_idx].valid;
    assign fetch_accept = fetch_valid && fetch_ready;

    // Hazard check against registered scoreboard state only (no writeback bypass)
    always_comb begin
        slot_valid = '0;
        eligible   = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            slot_valid[w] = slot_q[w].valid;
            eligible[w]   = slot_q[w].valid
                          && !sb_q[w][reg_field(slot_q[w].instr, RS1_LSB)]
                          && !sb_q[w][reg_field(slot_q[w].instr, RS2_LSB)]
                          && !(slot_q[w].wr_rd && sb_q[w][reg_field(slot_q[w].instr, RD_LSB)]);
        end
    end

    rr_arbiter #(.N(NUM_WARPS)) u_rr_arbiter (
        .req_i       (eligible),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .idx_o       (pick_idx),
        .any_grant_o (any_elig)
    );

    // Output register is free when empty or being consumed this cycle
    assign load = (!exec_valid_q || exec_ready) && any_elig;

    // Next-state for slots, scoreboard and round-robin pointer
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later lines see earlier updates, e.g. set-after-clear.
        for (int w = 0; w < NUM_WARPS; w++) begin
            slot_d[w] = slot_q[w];
            sb_d[w]   = sb_q[w];
            if (load && grant[w]) begin
                slot_d[w].valid = 1'b0;
            end
            if (fetch_accept && fetch_idx == WW'(w)) begin
                slot_d[w].valid = 1'b1;
                slot_d[w].instr = fetch_instr;
                slot_d[w].mask  = fetch_mask;
                slot_d[w].wr_rd = fetch_wr_rd;
            end
            // Writeback clears first so a same-cycle issue to the same register wins
            if (wb_valid && wb_in_range && wb_idx == WW'(w) && wb_rd != '0) begin
                sb_d[w][wb_rd] = 1'b0;
            end
            if (load && grant[w] && slot_q[w].wr_rd
                && reg_field(slot_q[w].instr, RD_LSB) != '0) begin
                sb_d[w][reg_field(slot_q[w].instr, RD_LSB)] = 1'b1;
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (load) begin
            rr_ptr_d = (pick_idx == WW'(NUM_WARPS - 1)) ? '0 : pick_idx + WW'(1);
        end
    end

    // State registers: slots, scoreboard, pointer and the issue output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the slot and scoreboard arrays are flops, not RAM, so reset clears them all at once.
            for (int w = 0; w < NUM_WARPS; w++) begin
                slot_q[w] <= '0;
                sb_q[w]   <= '0;
            end
            rr_ptr_q       <= '0;
            exec_valid_q   <= 1'b0;
            exec_instr_q   <= '0;
            exec_mask_q    <= '0;
            exec_warp_id_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
            for (int w = 0; w < NUM_WARPS; w++) begin
                slot_q[w] <= slot_d[w];
                sb_q[w]   <= sb_d[w];
            end
            rr_ptr_q <= rr_ptr_d;
            if (load) begin
                exec_valid_q   <= 1'b1;
                exec_instr_q   <= slot_q[pick_idx].instr;
                exec_mask_q    <= slot_q[pick_idx].mask;
                exec_warp_id_q <= WID_W'(pick_idx);
            end else if (exec_ready) begin
                exec_valid_q <= 1'b0;
            end
        end
    end

    assign exec_valid   = exec_valid_q;
    assign exec_instr   = exec_instr_q;
    assign exec_mask    = exec_mask_q;
    assign exec_warp_id = exec_warp_id_q;

`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_hazard_cnt_q;
    logic [31:0] stall_exec_cnt_q;

    // Saturating counts of hazard-blocked cycles and back-pressured cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_hazard_cnt_q <= '0;
            stall_exec_cnt_q   <= '0;
        end else begin
            if ((|slot_valid) && !any_elig && stall_hazard_cnt_q != 32'hFFFF_FFFF) begin
                stall_hazard_cnt_q <= stall_hazard_cnt_q + 32'd1;
            end
            if (exec_valid_q && !exec_ready && stall_exec_cnt_q != 32'hFFFF_FFFF) begin
                stall_exec_cnt_q <= stall_exec_cnt_q + 32'd1;
            end
        end
    end

    assign stall_hazard_cnt = stall_hazard_cnt_q;
    assign stall_exec_cnt   = stall_exec_cnt_q;
`endif

    // Fetch must never target an occupied slot
    a_fetch_into_free_slot : assert property (
        @(posedge clk) disable iff (!rst_n) fetch_valid |-> fetch_ready
    );

endmodule
